// File: rtl/prime_sieve_core.sv
// prime_sieve_core
//   Sieve-of-Eratosthenes engine behind a method/field handshake.
//   A host pulses run_req, polls the finish flag, then reads the prime count
//   and the largest prime below N. After a completed run, isprime queries
//   return the primality of any operand from the sieve bitmap.
//
// Parameters
//   N   sieve limit; candidates 0..N-1 (4 <= N <= 2**AW)
//   AW  index width
//
// Ports
//   clk, reset                    clock, synchronous active-high reset
//   run_req / run_busy            start a sieve run / run in progress
//   field_finish_flag_output      finish flag value
//   field_finish_flag_input(_we)  host write data / write enable for the flag
//   field_prime_count_output      number of primes < N from last run
//   field_last_prime_output       largest prime < N from last run
//   isprime_req / isprime_n       query request and operand
//   isprime_busy / isprime_return query in progress / query result
module prime_sieve_core #(
  parameter int unsigned N  = 256,
  parameter int unsigned AW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          run_req,
  output logic          run_busy,
  output logic          field_finish_flag_output,
  input  logic          field_finish_flag_input,
  input  logic          field_finish_flag_input_we,
  output logic [AW:0]   field_prime_count_output,
  output logic [AW-1:0] field_last_prime_output,
  input  logic          isprime_req,
  input  logic [AW-1:0] isprime_n,
  output logic          isprime_busy,
  output logic          isprime_return
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_OUTER,
    S_TEST,
    S_MARK,
    S_COUNT,
    S_DONE,
    S_QUERY
  } state_t;

  localparam logic [AW:0]      N_W    = (AW+1)'(N);
  localparam logic [AW:0]      N_LAST = (AW+1)'(N - 1);
  localparam logic [2*AW-1:0]  N_SQ   = (2*AW)'(N);
  localparam logic [AW:0]      ONE_W  = (AW+1)'(1);
  localparam logic [AW:0]      TWO_W  = (AW+1)'(2);
  localparam logic [AW-1:0]    ONE_I  = AW'(1);
  localparam logic [AW-1:0]    TWO_I  = AW'(2);

  state_t state, state_next;

  // Sieve bitmap: one write port, one registered read port.
  logic          mem [N];
  logic          rd_data;
  logic [AW-1:0] rd_addr;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic          wr_data;

  logic [AW-1:0]   i;
  logic [AW:0]     j;
  logic [AW:0]     k;
  logic            pend;
  logic [AW-1:0]   pend_k;
  logic [AW:0]     cnt_sh;
  logic [AW-1:0]   last_sh;
  logic            valid;
  logic            finish;
  logic [AW-1:0]   q_n;
  logic            q_phase;

  logic [2*AW-1:0] i_sq;
  logic [AW:0]     j_step;
  logic            q_in_range;

  assign i_sq       = {{AW{1'b0}}, i} * {{AW{1'b0}}, i};
  assign j_step     = j + {1'b0, i};
  assign q_in_range = ({1'b0, q_n} < N_W);

  assign field_finish_flag_output = finish;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    rd_data <= mem[rd_addr];
  end

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    wr_en      = 1'b0;
    wr_addr    = '0;
    wr_data    = 1'b0;
    rd_addr    = '0;
    case (state)
      S_IDLE: begin
        if (run_req)          state_next = S_INIT;
        else if (isprime_req) state_next = S_QUERY;
      end
      S_INIT: begin
        wr_en   = 1'b1;
        wr_addr = k[AW-1:0];
        wr_data = 1'b1;
        if (k == N_LAST) state_next = S_OUTER;
      end
      S_OUTER: begin
        if (i_sq >= N_SQ) begin
          state_next = S_COUNT;
        end else begin
          rd_addr    = i;
          state_next = S_TEST;
        end
      end
      S_TEST: begin
        state_next = rd_data ? S_MARK : S_OUTER;
      end
      S_MARK: begin
        // j < N is guaranteed on entry, so the exit test looks one step
        // ahead and MARK spends exactly one cycle per cleared multiple.
        wr_en   = 1'b1;
        wr_addr = j[AW-1:0];
        wr_data = 1'b0;
        if (j_step >= N_W) state_next = S_OUTER;
      end
      S_COUNT: begin
        if (k < N_W) rd_addr = k[AW-1:0];
        if (k == N_W) state_next = S_DONE;
      end
      S_DONE: begin
        state_next = S_IDLE;
      end
      S_QUERY: begin
        rd_addr = q_in_range ? q_n : '0;
        if (q_phase) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      run_busy                 <= 1'b0;
      isprime_busy             <= 1'b0;
      isprime_return           <= 1'b0;
      field_prime_count_output <= '0;
      field_last_prime_output  <= '0;
      valid                    <= 1'b0;
      i                        <= '0;
      j                        <= '0;
      k                        <= '0;
      pend                     <= 1'b0;
      pend_k                   <= '0;
      cnt_sh                   <= '0;
      last_sh                  <= '0;
      q_n                      <= '0;
      q_phase                  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (run_req) begin
            run_busy <= 1'b1;
            i        <= TWO_I;
            k        <= '0;
          end else if (isprime_req) begin
            isprime_busy <= 1'b1;
            q_n          <= isprime_n;
            q_phase      <= 1'b0;
          end
        end
        S_INIT: begin
          k <= k + ONE_W;
        end
        S_OUTER: begin
          if (i_sq >= N_SQ) begin
            k       <= TWO_W;
            pend    <= 1'b0;
            cnt_sh  <= '0;
            last_sh <= '0;
          end
        end
        S_TEST: begin
          if (rd_data) j <= i_sq[AW:0];
          else         i <= i + ONE_I;
        end
        S_MARK: begin
          j <= j_step;
          if (j_step >= N_W) i <= i + ONE_I;
        end
        S_COUNT: begin
          // Read of k is issued this cycle; data for the previous k
          // (pend_k) arrives this cycle and is tallied.
          if (k < N_W) begin
            k      <= k + ONE_W;
            pend_k <= k[AW-1:0];
          end
          pend <= (k < N_W);
          if (pend && rd_data) begin
            cnt_sh  <= cnt_sh + ONE_W;
            last_sh <= pend_k;
          end
        end
        S_DONE: begin
          run_busy                 <= 1'b0;
          valid                    <= 1'b1;
          field_prime_count_output <= cnt_sh;
          field_last_prime_output  <= last_sh;
        end
        S_QUERY: begin
          q_phase <= 1'b1;
          if (q_phase) begin
            isprime_busy   <= 1'b0;
            isprime_return <= valid && (q_n >= TWO_I) && q_in_range && rd_data;
          end
        end
        default: ;
      endcase
    end
  end

  // Host writes take precedence over the engine's own clear/set.
  always_ff @(posedge clk) begin
    if (reset)                             finish <= 1'b0;
    else if (field_finish_flag_input_we)   finish <= field_finish_flag_input;
    else if (state == S_IDLE && run_req)   finish <= 1'b0;
    else if (state == S_DONE)              finish <= 1'b1;
  end

endmodule

// File: tb/tb_prime_sieve_core.sv
module tb_prime_sieve_core;

  logic       clk;
  logic       rst     [3];
  logic       run_req [3];
  logic       ff_in   [3];
  logic       ff_we   [3];
  logic       iq_req  [3];
  logic [7:0] iq_n    [3];
  logic       run_busy[3];
  logic       ff_out  [3];
  logic [8:0] cnt     [3];
  logic [7:0] last    [3];
  logic       iq_busy [3];
  logic       iq_ret  [3];

  int checks = 0;
  int fails  = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instance 0: N=32, instance 1: N=256, instance 2: N=4 (all AW=8).
  prime_sieve_core #(.N(32), .AW(8)) u_n32 (
    .clk(clk), .reset(rst[0]), .run_req(run_req[0]), .run_busy(run_busy[0]),
    .field_finish_flag_output(ff_out[0]), .field_finish_flag_input(ff_in[0]),
    .field_finish_flag_input_we(ff_we[0]), .field_prime_count_output(cnt[0]),
    .field_last_prime_output(last[0]), .isprime_req(iq_req[0]), .isprime_n(iq_n[0]),
    .isprime_busy(iq_busy[0]), .isprime_return(iq_ret[0])
  );

  prime_sieve_core #(.N(256), .AW(8)) u_n256 (
    .clk(clk), .reset(rst[1]), .run_req(run_req[1]), .run_busy(run_busy[1]),
    .field_finish_flag_output(ff_out[1]), .field_finish_flag_input(ff_in[1]),
    .field_finish_flag_input_we(ff_we[1]), .field_prime_count_output(cnt[1]),
    .field_last_prime_output(last[1]), .isprime_req(iq_req[1]), .isprime_n(iq_n[1]),
    .isprime_busy(iq_busy[1]), .isprime_return(iq_ret[1])
  );

  prime_sieve_core #(.N(4), .AW(8)) u_n4 (
    .clk(clk), .reset(rst[2]), .run_req(run_req[2]), .run_busy(run_busy[2]),
    .field_finish_flag_output(ff_out[2]), .field_finish_flag_input(ff_in[2]),
    .field_finish_flag_input_we(ff_we[2]), .field_prime_count_output(cnt[2]),
    .field_last_prime_output(last[2]), .isprime_req(iq_req[2]), .isprime_n(iq_n[2]),
    .isprime_busy(iq_busy[2]), .isprime_return(iq_ret[2])
  );

  task automatic check_all_zero(input int d, input string tag);
    checks++;
    if ({run_busy[d], ff_out[d], iq_busy[d], iq_ret[d]} !== 4'b0000) begin
      fails++;
      $display("FAIL %s_flags[%0d]: got busy/finish/qbusy/qret=%b%b%b%b expected 0000",
               tag, d, run_busy[d], ff_out[d], iq_busy[d], iq_ret[d]);
    end
    checks++;
    if (cnt[d] !== 9'd0 || last[d] !== 8'd0) begin
      fails++;
      $display("FAIL %s_fields[%0d]: got count=%0d last=%0d expected 0 0", tag, d, cnt[d], last[d]);
    end
  endtask

  task automatic do_run(input int d, input int ec, input int el, input string tag);
    int n;
    @(negedge clk); run_req[d] = 1'b1;
    @(negedge clk); run_req[d] = 1'b0;
    checks++;
    if (run_busy[d] !== 1'b1) begin
      fails++;
      $display("FAIL %s_busy_rise: got %b expected 1", tag, run_busy[d]);
    end
    n = 0;
    while (ff_out[d] !== 1'b1 && n < 4000) begin
      @(negedge clk); n++;
    end
    checks++;
    if (ff_out[d] !== 1'b1) begin
      fails++;
      $display("FAIL %s_timeout: got finish=%b expected 1", tag, ff_out[d]);
    end else begin
      checks++;
      if (run_busy[d] !== 1'b0) begin
        fails++;
        $display("FAIL %s_busy_fall: got %b expected 0", tag, run_busy[d]);
      end
      checks++;
      if (cnt[d] !== 9'(ec)) begin
        fails++;
        $display("FAIL %s_count: got %0d expected %0d", tag, cnt[d], ec);
      end
      checks++;
      if (last[d] !== 8'(el)) begin
        fails++;
        $display("FAIL %s_last: got %0d expected %0d", tag, last[d], el);
      end
    end
  endtask

  task automatic do_query(input int d, input int n, input logic exp, input string tag);
    int bc;
    @(negedge clk); iq_req[d] = 1'b1; iq_n[d] = 8'(n);
    @(negedge clk); iq_req[d] = 1'b0;
    bc = 0;
    while (iq_busy[d] === 1'b1 && bc < 10) begin
      bc++; @(negedge clk);
    end
    checks++;
    if (bc != 2) begin
      fails++;
      $display("FAIL %s_busy_len n=%0d: got %0d cycles expected 2", tag, n, bc);
    end
    checks++;
    if (iq_ret[d] !== exp) begin
      fails++;
      $display("FAIL %s_result n=%0d: got %b expected %b", tag, n, iq_ret[d], exp);
    end
  endtask

  task automatic test_reset();
    for (int d = 0; d < 3; d++) begin
      rst[d] = 1'b1; run_req[d] = 1'b0; ff_in[d] = 1'b0; ff_we[d] = 1'b0;
      iq_req[d] = 1'b0; iq_n[d] = '0;
    end
    repeat (2) @(negedge clk);
    for (int d = 0; d < 3; d++) check_all_zero(d, "reset");
    for (int d = 0; d < 3; d++) rst[d] = 1'b0;
  endtask

  task automatic test_query_no_run();
    do_query(0, 7, 1'b0, "norun_q7");
    do_query(2, 3, 1'b0, "norun_q3");
  endtask

  task automatic test_n32();
    do_run(0, 11, 31, "n32");
    do_query(0, 31, 1'b1, "n32_q");
    do_query(0, 25, 1'b0, "n32_q");
    do_query(0, 32, 1'b0, "n32_q");
    do_query(0, 2,  1'b1, "n32_q");
  endtask

  task automatic test_n256();
    do_run(1, 54, 251, "n256");
    do_query(1, 251, 1'b1, "n256_q");
    do_query(1, 255, 1'b0, "n256_q");
    do_query(1, 2,   1'b1, "n256_q");
    do_query(1, 1,   1'b0, "n256_q");
    do_query(1, 0,   1'b0, "n256_q");
  endtask

  task automatic test_n4();
    do_run(2, 2, 3, "n4");
    do_query(2, 3, 1'b1, "n4_q");
    do_query(2, 4, 1'b0, "n4_q");
  endtask

  task automatic test_reset_mid_mark();
    @(negedge clk); run_req[0] = 1'b1;
    @(negedge clk); run_req[0] = 1'b0;
    repeat (38) @(negedge clk);
    // Engine is now clearing multiples of 2; old results must still show.
    checks++;
    if (cnt[0] !== 9'd11 || run_busy[0] !== 1'b1) begin
      fails++;
      $display("FAIL midrun_hold: got count=%0d busy=%b expected 11 1", cnt[0], run_busy[0]);
    end
    rst[0] = 1'b1;
    @(negedge clk);
    rst[0] = 1'b0;
    check_all_zero(0, "midmark_reset");
    do_run(0, 11, 31, "after_reset");
  endtask

  task automatic test_finish_flag();
    int n;
    ff_we[2] = 1'b1; ff_in[2] = 1'b0;
    @(negedge clk); run_req[2] = 1'b1;
    @(negedge clk); run_req[2] = 1'b0;
    n = 0;
    while (run_busy[2] === 1'b1 && n < 500) begin
      @(negedge clk); n++;
    end
    checks++;
    if (run_busy[2] !== 1'b0 || ff_out[2] !== 1'b0) begin
      fails++;
      $display("FAIL flag_write_wins: got busy=%b finish=%b expected 0 0", run_busy[2], ff_out[2]);
    end
    checks++;
    if (cnt[2] !== 9'd2 || last[2] !== 8'd3) begin
      fails++;
      $display("FAIL flag_run_fields: got count=%0d last=%0d expected 2 3", cnt[2], last[2]);
    end
    ff_in[2] = 1'b1;
    @(negedge clk); ff_we[2] = 1'b0; ff_in[2] = 1'b0;
    checks++;
    if (ff_out[2] !== 1'b1) begin
      fails++;
      $display("FAIL flag_host_set: got %b expected 1", ff_out[2]);
    end
    run_req[2] = 1'b1;
    @(negedge clk); run_req[2] = 1'b0;
    checks++;
    if (ff_out[2] !== 1'b0 || run_busy[2] !== 1'b1) begin
      fails++;
      $display("FAIL flag_clear_on_run: got finish=%b busy=%b expected 0 1", ff_out[2], run_busy[2]);
    end
    n = 0;
    while (ff_out[2] !== 1'b1 && n < 500) begin
      @(negedge clk); n++;
    end
    checks++;
    if (ff_out[2] !== 1'b1 || cnt[2] !== 9'd2) begin
      fails++;
      $display("FAIL flag_rerun_done: got finish=%b count=%0d expected 1 2", ff_out[2], cnt[2]);
    end
  endtask

  task automatic test_back_to_back();
    int  c;
    logic q_seen;
    @(negedge clk); run_req[0] = 1'b1; iq_req[0] = 1'b1; iq_n[0] = 8'd5;
    @(negedge clk); run_req[0] = 1'b0; iq_req[0] = 1'b0;
    checks++;
    if (run_busy[0] !== 1'b1 || iq_busy[0] !== 1'b0) begin
      fails++;
      $display("FAIL concurrent_prio: got run_busy=%b isprime_busy=%b expected 1 0", run_busy[0], iq_busy[0]);
    end
    c = 0; q_seen = 1'b0;
    while (ff_out[0] !== 1'b1 && c < 2000) begin
      @(negedge clk); c++;
      if (iq_busy[0] === 1'b1) q_seen = 1'b1;
      run_req[0] = (c == 10 || c == 40 || c == 80);
      iq_req[0]  = (c == 20);
    end
    run_req[0] = 1'b0; iq_req[0] = 1'b0;
    checks++;
    if (ff_out[0] !== 1'b1 || cnt[0] !== 9'd11 || last[0] !== 8'd31 || q_seen !== 1'b0) begin
      fails++;
      $display("FAIL busy_ignore: got finish=%b count=%0d last=%0d qseen=%b expected 1 11 31 0",
               ff_out[0], cnt[0], last[0], q_seen);
    end
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (run_busy[0] !== 1'b0 || ff_out[0] !== 1'b1) begin
        fails++;
        $display("FAIL no_queued_run: got busy=%b finish=%b expected 0 1", run_busy[0], ff_out[0]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_query_no_run();
    test_n32();
    test_n256();
    test_n4();
    test_reset_mid_mark();
    test_finish_flag();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
